tf_seq_ctrl: RTL and testbench
==============================

TF_SEQ_CTRL -- requirements
Module: tf_seq_ctrl

Interface
REQ-001 SHALL have parameter IT_DEPTH, default 3: number of twiddle-factor rows to generate after row 0.
REQ-002 SHALL have parameter MUL_LAT, default 4: Barrett-multiplier latency in cycles, range 1..15.
REQ-003 SHALL have parameter LANES, default 15: twiddle lanes per row.
REQ-004 SHALL have parameter CONST_BANK, default 15: depth of the constant table indexed by idx.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin generation; sampled in IDLE only.
REQ-008 mode_l  in  `D_width  NTT stage mode; latched at accepted start.
REQ-009 serve_req  in  1  consumer read request, valid in SERVE only.
REQ-010 serve_depth  in  `D_width  row requested by the consumer.
REQ-011 finish  in  1  consumer releases the table; SERVE goes to IDLE.
REQ-012 TF_ren  out  1  table read strobe to the twiddle generator.
REQ-013 TF_wen  out  1  table write-back strobe to the twiddle generator.
REQ-014 it_depth_cnt  out  `D_width  row address, shared by read and write.
REQ-015 l  out  `D_width  latched mode_l.
REQ-016 idx  out  LANES x `D_width  per-lane constant index.
REQ-017 tf_valid  out  1  the generator's row outputs are valid this cycle.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 gen_done  out  1  one-cycle pulse when generation completes.

Function
REQ-020 All outputs SHALL be registered (Moore).
- States: IDLE, GEN_RD, GEN_WAIT, GEN_WR, SERVE.
REQ-021 IDLE with start=1 SHALL go to GEN_RD, set d=0 and latch mode_l into l; start is ignored in every other state.
REQ-022 GEN_RD SHALL last 1 cycle:
- TF_ren=1, TF_wen=0, it_depth_cnt=d.
- idx[k] = (d+k) mod CONST_BANK for k=0..LANES-1.
REQ-023 GEN_WAIT SHALL last exactly MUL_LAT cycles with TF_ren=TF_wen=0, counted by a wait counter that is cleared on entry.
REQ-024 GEN_WR SHALL last 1 cycle: TF_wen=1, TF_ren=0, it_depth_cnt=d+1.
- If d+1==IT_DEPTH, go to SERVE and pulse gen_done in the first SERVE cycle.
- Otherwise d increments and the state returns to GEN_RD.
REQ-025 One generation iteration SHALL take MUL_LAT+2 cycles; the full sequence takes IT_DEPTH*(MUL_LAT+2) cycles.
REQ-026 In SERVE, serve_req=1 SHALL give TF_ren=1 and it_depth_cnt=serve_depth the next cycle, and tf_valid=1 the cycle after that.
- Back-to-back requests are accepted every cycle.
REQ-027 A serve_depth greater than IT_DEPTH SHALL be clamped to IT_DEPTH.
REQ-028 finish in SERVE SHALL return the block to IDLE the next cycle.
- If serve_req and finish are both high, the request is still served, and its tf_valid still fires, before IDLE.
REQ-029 TF_ren and TF_wen SHALL never be high in the same cycle.
REQ-030 In IDLE, TF_ren, TF_wen, it_depth_cnt, idx and tf_valid SHALL all be 0.
REQ-031 The d and wait counters SHALL compare without wrap.
- d width is clog2(IT_DEPTH+1).
- idx uses an explicit modulo wrap at CONST_BANK.

Reset
REQ-032 rst=1 SHALL force the following on the next edge, including mid-generation and mid-SERVE:
- state IDLE;
- d, wait counter, l and idx at 0;
- TF_ren, TF_wen, tf_valid, busy and gen_done at 0.
REQ-033 No output SHALL pulse in the cycle after reset is released unless start is sampled.

Structure
REQ-034 The state enum, `D_width and the LANES/CONST_BANK/IT_DEPTH defaults SHALL live in the shared NWC package.
REQ-035 Per-lane idx generation SHALL be one sub-module, tf_idx_gen: combinational modulo adder, registered in the parent.
REQ-036 The FSM, counters and SERVE pipeline SHALL remain in tf_seq_ctrl.

Verification
REQ-037 Nominal run (IT_DEPTH=3, MUL_LAT=4), start at cycle 0 ->
- TF_ren at cycles 1, 7, 13 with depth 0, 1, 2;
- TF_wen at cycles 6, 12, 18 with depth 1, 2, 3;
- gen_done at cycle 19.
REQ-038 idx check: in the cycle-13 read (d=2), idx[0]=2 and idx[14]=(2+14) mod 15=1.
REQ-039 SERVE: serve_req at cycles 20, 21, 22 with depth 3, 0, 9 ->
- TF_ren cycles 21..23 with it_depth_cnt 3, 0, 3 (9 clamped);
- tf_valid cycles 22..24.
REQ-040 rst high at cycle 9 (in GEN_WAIT) -> at cycle 10 state is IDLE, all outputs 0, and no TF_wen appears at cycle 12.
REQ-041 start held high during generation -> the sequence is not restarted and timing is identical to REQ-037.
REQ-042 serve_req and finish both high in SERVE -> that one read is served, tf_valid fires, then busy=0.

Source files
------------

// File: rtl/tf_seq_ctrl_pkg.sv
// Shared types and defaults for the twiddle-factor sequence controller.
// Holds the FSM state encoding, the data-word width and the modulo-index helper.
package tf_seq_ctrl_pkg;

  localparam int unsigned D_WIDTH        = 5;
  localparam int unsigned DEF_IT_DEPTH   = 3;
  localparam int unsigned DEF_MUL_LAT    = 4;
  localparam int unsigned DEF_LANES      = 15;
  localparam int unsigned DEF_CONST_BANK = 15;

  typedef logic [D_WIDTH-1:0] dword_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN_RD,
    S_GEN_WAIT,
    S_GEN_WR,
    S_SERVE
  } tf_state_e;

  // (base + k) mod bank, with both operands reduced first so the sum wraps once
  function automatic dword_t idx_wrap(input int unsigned base,
                                      input int unsigned k,
                                      input int unsigned bank);
    int unsigned s;
    s = (base % bank) + (k % bank);
    if (s >= bank) s = s - bank;
    return dword_t'(s);
  endfunction

endpackage

// File: rtl/tf_seq_ctrl_if.sv
// Request/response bundle between the consumer/generator side and tf_seq_ctrl.
// The master drives start/serve requests; the slave (controller) drives table strobes.
interface tf_seq_ctrl_if
  import tf_seq_ctrl_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES
);

  logic   start;
  dword_t mode_l;
  logic   serve_req;
  dword_t serve_depth;
  logic   finish;

  logic   TF_ren;
  logic   TF_wen;
  dword_t it_depth_cnt;
  dword_t l;
  logic [LANES-1:0][D_WIDTH-1:0] idx;
  logic   tf_valid;
  logic   busy;
  logic   gen_done;

  modport master (
    output start, mode_l, serve_req, serve_depth, finish,
    input  TF_ren, TF_wen, it_depth_cnt, l, idx, tf_valid, busy, gen_done
  );

  modport slave (
    input  start, mode_l, serve_req, serve_depth, finish,
    output TF_ren, TF_wen, it_depth_cnt, l, idx, tf_valid, busy, gen_done
  );

endinterface

// File: rtl/tf_seq_ctrl_idx.sv
// Per-lane constant index generator: idx[k] = (base + k) mod CONST_BANK.
// Purely combinational; the parent registers the result on entry to a read.
module tf_idx_gen
  import tf_seq_ctrl_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned CONST_BANK = DEF_CONST_BANK,
  parameter int unsigned BW         = 2
) (
  input  logic [BW-1:0]                  base_i,
  output logic [LANES-1:0][D_WIDTH-1:0]  idx_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx_o[k] = idx_wrap(32'(base_i), k, CONST_BANK);
    end
  end

endmodule

// File: rtl/tf_seq_ctrl.sv
// Twiddle-factor sequencer: generates IT_DEPTH rows (read, multiply wait, write-back),
// then serves consumer row reads until released. All outputs are registered.
module tf_seq_ctrl
  import tf_seq_ctrl_pkg::*;
#(
  parameter int unsigned IT_DEPTH   = DEF_IT_DEPTH,
  parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned CONST_BANK = DEF_CONST_BANK
) (
  input  logic              clk,
  input  logic              rst,
  tf_seq_ctrl_if.slave      bus
);

  localparam int unsigned DW = $clog2(IT_DEPTH + 1);
  localparam int unsigned WW = $clog2(MUL_LAT + 1);

  tf_state_e                    state_q;
  logic [DW-1:0]                d_q, d_d;
  logic [WW-1:0]                wait_q;
  dword_t                       l_q;
  logic                         ren_q, wen_q, valid_q, busy_q, done_q;
  dword_t                       cnt_q;
  logic [LANES-1:0][D_WIDTH-1:0] idx_q, idx_d;
  logic                         serve_rd_q, fin_pend_q;
  dword_t                       serve_addr;
  logic                         last_row;

  // Row that the next GEN_RD will read: 0 from IDLE, d+1 after a write-back
  always_comb begin
    d_d = '0;
    if (state_q == S_GEN_WR) d_d = d_q + 1'b1;
  end

  assign last_row   = (32'(d_q) + 32'd1) == IT_DEPTH;
  assign serve_addr = (32'(bus.serve_depth) > IT_DEPTH) ? D_WIDTH'(IT_DEPTH) : bus.serve_depth;

  tf_idx_gen #(
    .LANES      (LANES),
    .CONST_BANK (CONST_BANK),
    .BW         (DW)
  ) u_idx (
    .base_i (d_d),
    .idx_o  (idx_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      wait_q     <= '0;
      l_q        <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      serve_rd_q <= 1'b0;
      fin_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
          idx_q   <= '0;
          if (bus.start) begin
            state_q <= S_GEN_RD;
            d_q     <= '0;
            l_q     <= bus.mode_l;
            ren_q   <= 1'b1;
            idx_q   <= idx_d;
            busy_q  <= 1'b1;
          end
        end

        S_GEN_RD: begin
          state_q <= S_GEN_WAIT;
          wait_q  <= '0;
          ren_q   <= 1'b0;
        end

        S_GEN_WAIT: begin
          if (32'(wait_q) == MUL_LAT - 32'd1) begin
            state_q <= S_GEN_WR;
            wen_q   <= 1'b1;
            cnt_q   <= D_WIDTH'(d_q) + 1'b1;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end

        S_GEN_WR: begin
          wen_q <= 1'b0;
          if (last_row) begin
            state_q <= S_SERVE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= S_GEN_RD;
            d_q     <= d_d;
            ren_q   <= 1'b1;
            cnt_q   <= D_WIDTH'(d_d);
            idx_q   <= idx_d;
          end
        end

        S_SERVE: begin
          valid_q <= serve_rd_q;
          // A finish that arrived with a request waits here until that read's tf_valid has fired
          if (fin_pend_q) begin
            ren_q      <= 1'b0;
            serve_rd_q <= 1'b0;
            cnt_q      <= '0;
            if (!serve_rd_q) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              valid_q    <= 1'b0;
              idx_q      <= '0;
              d_q        <= '0;
              fin_pend_q <= 1'b0;
            end
          end else if (bus.serve_req) begin
            ren_q      <= 1'b1;
            cnt_q      <= serve_addr;
            serve_rd_q <= 1'b1;
            fin_pend_q <= bus.finish;
          end else begin
            ren_q      <= 1'b0;
            serve_rd_q <= 1'b0;
            cnt_q      <= '0;
            if (bus.finish) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              idx_q   <= '0;
              d_q     <= '0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.TF_ren       = ren_q;
  assign bus.TF_wen       = wen_q;
  assign bus.it_depth_cnt = cnt_q;
  assign bus.l            = l_q;
  assign bus.idx          = idx_q;
  assign bus.tf_valid     = valid_q;
  assign bus.busy         = busy_q;
  assign bus.gen_done     = done_q;

endmodule

// File: tb/tb_tf_seq_ctrl.sv
// Scoreboard bench for tf_seq_ctrl: stimulus pushes hand-computed strobe events,
// a negedge monitor pops and compares every strobe the DUT raises.
module tb_tf_seq_ctrl;
  import tf_seq_ctrl_pkg::*;

  localparam int unsigned LN = 15;
  localparam int K_REN  = 0;
  localparam int K_WEN  = 1;
  localparam int K_VAL  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int cyc;
    int kind;
    int dep;
    int i0;
    int i14;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  tf_seq_ctrl_if #(.LANES(LN)) bus ();

  tf_seq_ctrl #(
    .IT_DEPTH   (3),
    .MUL_LAT    (4),
    .LANES      (LN),
    .CONST_BANK (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int k, input int d, input int i0, input int i14);
    exp_t e;
    e.cyc = c; e.kind = k; e.dep = d; e.i0 = i0; e.i14 = i14;
    sb.push_back(e);
  endtask

  // Generation strobes for a start accepted in cycle c
  task automatic push_gen(input int c);
    push(c + 1,  K_REN,  0, 0, 14);
    push(c + 6,  K_WEN,  1, -1, -1);
    push(c + 7,  K_REN,  1, 1, 0);
    push(c + 12, K_WEN,  2, -1, -1);
    push(c + 13, K_REN,  2, 2, 1);
    push(c + 18, K_WEN,  3, -1, -1);
    push(c + 19, K_DONE, -1, -1, -1);
  endtask

  task automatic check_evt(input int kind, input int dep, input int i0, input int i14);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL evt_unexpected: got kind=%0d cyc=%0d dep=%0d, want no event", kind, cyc, dep);
      return;
    end
    e = sb.pop_front();
    if (e.cyc != cyc || e.kind != kind || (e.dep >= 0 && e.dep != dep) ||
        (e.i0 >= 0 && (e.i0 != i0 || e.i14 != i14))) begin
      n_fail++;
      $display("FAIL evt: got kind=%0d cyc=%0d dep=%0d idx0=%0d idx14=%0d, want kind=%0d cyc=%0d dep=%0d idx0=%0d idx14=%0d",
               kind, cyc, dep, i0, i14, e.kind, e.cyc, e.dep, e.i0, e.i14);
    end
  endtask

  always @(negedge clk) begin
    if (bus.TF_ren || bus.TF_wen) chk("ren_wen_excl", int'(bus.TF_ren & bus.TF_wen), 0);
    if (bus.TF_ren)   check_evt(K_REN, int'(bus.it_depth_cnt), int'(bus.idx[0]), int'(bus.idx[LN-1]));
    if (bus.TF_wen)   check_evt(K_WEN, int'(bus.it_depth_cnt), -1, -1);
    if (bus.tf_valid) check_evt(K_VAL, -1, -1, -1);
    if (bus.gen_done) check_evt(K_DONE, -1, -1, -1);
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ren"},   int'(bus.TF_ren), 0);
    chk({tag, "_wen"},   int'(bus.TF_wen), 0);
    chk({tag, "_cnt"},   int'(bus.it_depth_cnt), 0);
    chk({tag, "_idx"},   int'(|bus.idx), 0);
    chk({tag, "_valid"}, int'(bus.tf_valid), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.gen_done), 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.mode_l      = '0;
    bus.serve_req   = 1'b0;
    bus.serve_depth = '0;
    bus.finish      = 1'b0;

    goto(3);
    rst = 1'b0;
    goto(4);
    chk_idle("rst");
    chk("rst_l", int'(bus.l), 0);

    // Nominal run, then three serve reads with a clamped depth
    push_gen(10);
    push(31, K_REN, 3, -1, -1);
    push(32, K_REN, 0, -1, -1);
    push(32, K_VAL, -1, -1, -1);
    push(33, K_REN, 3, -1, -1);
    push(33, K_VAL, -1, -1, -1);
    push(34, K_VAL, -1, -1, -1);
    goto(10);
    bus.start  = 1'b1;
    bus.mode_l = 5'd6;
    goto(11);
    bus.start = 1'b0;
    chk("a_busy_gen", int'(bus.busy), 1);
    chk("a_l", int'(bus.l), 6);
    goto(30);
    bus.serve_req = 1'b1; bus.serve_depth = 5'd3;
    goto(31);
    bus.serve_depth = 5'd0;
    goto(32);
    bus.serve_depth = 5'd9;
    goto(33);
    bus.serve_req = 1'b0;
    goto(36);
    chk("a_busy_serve", int'(bus.busy), 1);
    bus.finish = 1'b1;
    goto(37);
    bus.finish = 1'b0;
    chk_idle("a_fin");

    // start held through generation; serve_req with finish in the same cycle
    push_gen(50);
    push(71, K_REN, 2, -1, -1);
    push(72, K_VAL, -1, -1, -1);
    goto(50);
    bus.start  = 1'b1;
    bus.mode_l = 5'd3;
    goto(60);
    chk("b_l", int'(bus.l), 3);
    goto(68);
    bus.start = 1'b0;
    goto(70);
    bus.serve_req = 1'b1; bus.finish = 1'b1; bus.serve_depth = 5'd2;
    goto(71);
    bus.serve_req = 1'b0; bus.finish = 1'b0;
    chk("b_busy_rd", int'(bus.busy), 1);
    goto(72);
    chk("b_busy_valid", int'(bus.busy), 1);
    goto(73);
    chk_idle("b_fin");
    goto(75);
    chk("b_no_restart", int'(bus.busy), 0);

    // Reset during GEN_WAIT of the second row
    push(91, K_REN, 0, 0, 14);
    push(96, K_WEN, 1, -1, -1);
    push(97, K_REN, 1, 1, 0);
    goto(90);
    bus.start = 1'b1; bus.mode_l = 5'd7;
    goto(91);
    bus.start = 1'b0;
    goto(99);
    rst = 1'b1;
    goto(100);
    rst = 1'b0;
    chk_idle("c_rst");
    chk("c_rst_l", int'(bus.l), 0);
    goto(112);
    chk("c_sb_drained", sb.size(), 0);

    // Reset in SERVE wins over a simultaneous read request
    push_gen(120);
    goto(120);
    bus.start = 1'b1;
    goto(121);
    bus.start = 1'b0;
    goto(140);
    bus.serve_req = 1'b1; bus.serve_depth = 5'd1; rst = 1'b1;
    goto(141);
    bus.serve_req = 1'b0; rst = 1'b0;
    chk_idle("d_rst");
    goto(145);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
